// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the data_mem_hs data memory.
//               - RV32I load/store funct3 size codes
//               - FSM state encoding (2 bits)
//               - wait-state counter width
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_hs_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_hs_if
// Description : Request/response bus for data_mem_hs.
//               master : req_valid/req_we/req_funct3/req_addr/req_wdata out,
//                        req_ready/resp_valid/resp_rdata/resp_err in
//               slave  : the reverse directions
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_hs_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational byte-lane steering for RV32I loads/stores.
//               Ports: i_we, i_funct3, i_addr_lo[1:0], i_wdata, i_rword in;
//                      o_byte_en[3:0], o_wdata (lane-replicated store data),
//                      o_rdata (extended load data), o_misalign, o_illegal out.
//               Macro DMEM_MISALIGN_CHECK_EN: misaligned H/W accesses are
//               flagged; otherwise the low address bits are forced aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  wire logic        i_we,
    input  wire logic [2:0]  i_funct3,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [31:0] i_wdata,
    input  wire logic [31:0] i_rword,
    output logic      [3:0]  o_byte_en,
    output logic      [31:0] o_wdata,
    output logic      [31:0] o_rdata,
    output logic             o_misalign,
    output logic             o_illegal
);

    logic        w_is_h;
    logic        w_is_w;
    logic [1:0]  w_lane;
    logic        w_ok;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_is_h    = (i_funct3[1:0] == 2'b01);
        w_is_w    = (i_funct3 == F3_W);
        o_illegal = 1'b0;
        o_byte_en = 4'b0000;
        o_wdata   = 32'h0;
        o_rdata   = 32'h0;

        // Unsigned variants exist only for loads.
        case (i_funct3)
            F3_B, F3_H, F3_W: o_illegal = 1'b0;
            F3_BU, F3_HU:     o_illegal = i_we;
            default:          o_illegal = 1'b1;
        endcase

`ifdef DMEM_MISALIGN_CHECK_EN
        w_lane     = i_addr_lo;
        o_misalign = !o_illegal &&
                     ((w_is_h && i_addr_lo[0]) || (w_is_w && (i_addr_lo != 2'b00)));
`else
        if (w_is_w)
            w_lane = 2'b00;
        else if (w_is_h)
            w_lane = {i_addr_lo[1], 1'b0};
        else
            w_lane = i_addr_lo;
        o_misalign = 1'b0;
`endif

        w_ok   = !o_illegal && !o_misalign;
        w_byte = i_rword[{w_lane, 3'b000} +: 8];
        w_half = w_lane[1] ? i_rword[31:16] : i_rword[15:0];

        if (w_is_w) begin
            o_wdata = i_wdata;
        end else if (w_is_h) begin
            o_wdata = {2{i_wdata[15:0]}};
        end else begin
            o_wdata = {4{i_wdata[7:0]}};
        end

        if (w_ok && i_we) begin
            if (w_is_w)
                o_byte_en = 4'b1111;
            else if (w_is_h)
                o_byte_en = w_lane[1] ? 4'b1100 : 4'b0011;
            else
                o_byte_en = 4'b0001 << w_lane;
        end

        if (w_ok && !i_we) begin
            case (i_funct3)
                F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
                F3_BU:   o_rdata = {24'h0, w_byte};
                F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
                F3_HU:   o_rdata = {16'h0, w_half};
                F3_W:    o_rdata = i_rword;
                default: o_rdata = 32'h0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_hs
// Description : Byte-addressable RV32I data memory with valid/ready request
//               port and programmable wait states.
//               Ports: clk, rst (sync, active-high), bus (data_mem_hs_if.slave)
//               Parameters: ADDR_W (byte address width, 2**(ADDR_W-2) words),
//                           WAIT_CYCLES (0..15 stall cycles before response)
//               Macro DMEM_MISALIGN_CHECK_EN: report misaligned H/W accesses
//               as errors instead of force-aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_hs
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  wire logic    clk,
    input  wire logic    rst,
    data_mem_hs_if.slave bus
);

    localparam int c_DEPTH = 2 ** (ADDR_W - 2);
    localparam logic [WAIT_CNT_W-1:0] c_WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t                  r_state;
    state_t                  w_next;
    logic [WAIT_CNT_W-1:0]   r_cnt;
    logic                    r_we;
    logic [2:0]              r_funct3;
    logic [ADDR_W-1:0]       r_addr;
    logic [31:0]             r_wdata;
    logic                    r_resp_valid;
    logic [31:0]             r_resp_rdata;
    logic                    r_resp_err;
    logic [31:0]             r_mem [c_DEPTH];

    logic                    w_idle;
    logic                    w_accept;
    logic                    w_enter_resp;
    logic                    w_we;
    logic [2:0]              w_funct3;
    logic [ADDR_W-1:0]       w_addr;
    logic [31:0]             w_wdata;
    logic [ADDR_W-3:0]       w_idx;
    logic [31:0]             w_rword;
    logic [3:0]              w_byte_en;
    logic [31:0]             w_wdata_sh;
    logic [31:0]             w_rdata_ext;
    logic                    w_misalign;
    logic                    w_illegal;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && bus.req_valid && !rst;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid)
                    w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: begin
                if (r_cnt == '0)
                    w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // The array is accessed on the edge entering RESP. With no wait states
    // that is the accept edge itself, so the live request is used instead of
    // the (not yet loaded) latched copy.
    assign w_enter_resp = (w_next == ST_RESP);
    assign w_we         = w_idle ? bus.req_we                  : r_we;
    assign w_funct3     = w_idle ? bus.req_funct3              : r_funct3;
    assign w_addr       = w_idle ? bus.req_addr[ADDR_W-1:0]    : r_addr;
    assign w_wdata      = w_idle ? bus.req_wdata               : r_wdata;
    assign w_idx        = w_addr[ADDR_W-1:2];
    assign w_rword      = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_we       (w_we),
        .i_funct3   (w_funct3),
        .i_addr_lo  (w_addr[1:0]),
        .i_wdata    (w_wdata),
        .i_rword    (w_rword),
        .o_byte_en  (w_byte_en),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_rdata_ext),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byte_en[b])
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
        end
    end

    // ---------------- request latch, wait counter, response ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr[ADDR_W-1:0];
                r_wdata  <= bus.req_wdata;
                r_cnt    <= c_WAIT_LOAD;
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_enter_resp) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= w_rdata_ext;
                r_resp_err   <= w_illegal | w_misalign;
            end else begin
                r_resp_valid <= 1'b0;
                r_resp_rdata <= 32'h0;
                r_resp_err   <= 1'b0;
            end
        end
    end

    // Outputs are masked by rst so they read zero for the whole reset window,
    // including the portion before the first reset edge.
    assign bus.req_ready  = w_idle && !rst;
    assign bus.resp_valid = r_resp_valid && !rst;
    assign bus.resp_rdata = rst ? 32'h0 : r_resp_rdata;
    assign bus.resp_err   = r_resp_err && !rst;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_hs
// Description : Self-checking bench for data_mem_hs. Instance 0 has no wait
//               states, instance 1 has three. Expected responses are queued
//               at issue time and checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_hs;
    import dmem_pkg::*;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit c_MCHK = 1'b1;
`else
    localparam bit c_MCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic [1:0] rst;
    always #5 clk = ~clk;

    data_mem_hs_if #(.ADDR_W(8)) bus0 ();
    data_mem_hs_if #(.ADDR_W(8)) bus1 ();

    data_mem_hs #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst[0]), .bus(bus0));
    data_mem_hs #(.ADDR_W(8), .WAIT_CYCLES(3)) u_dut1 (.clk(clk), .rst(rst[1]), .bus(bus1));

    logic [1:0]       d_valid, d_we;
    logic [1:0][2:0]  d_f3;
    logic [1:0][7:0]  d_addr;
    logic [1:0][31:0] d_wdata;
    logic [1:0]       m_ready, m_rvalid, m_err;
    logic [1:0][31:0] m_rdata;

    assign bus0.req_valid = d_valid[0];  assign bus1.req_valid = d_valid[1];
    assign bus0.req_we    = d_we[0];     assign bus1.req_we    = d_we[1];
    assign bus0.req_funct3= d_f3[0];     assign bus1.req_funct3= d_f3[1];
    assign bus0.req_addr  = d_addr[0];   assign bus1.req_addr  = d_addr[1];
    assign bus0.req_wdata = d_wdata[0];  assign bus1.req_wdata = d_wdata[1];
    assign m_ready  = {bus1.req_ready,  bus0.req_ready};
    assign m_rvalid = {bus1.resp_valid, bus0.resp_valid};
    assign m_err    = {bus1.resp_err,   bus0.resp_err};
    assign m_rdata  = {bus1.resp_rdata, bus0.resp_rdata};

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic int waits(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drive one request and wait for it to be accepted (bounded).
    task automatic drive_req(input int i, input logic we, input logic [2:0] f3,
                             input logic [7:0] addr, input logic [31:0] wd);
        int n;
        @(negedge clk);
        d_valid[i] = 1'b1; d_we[i] = we; d_f3[i] = f3;
        d_addr[i]  = addr; d_wdata[i] = wd;
        n = 0;
        while (!m_ready[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20)
            check($sformatf("inst%0d accept timeout", i), 32'd0, 32'd1);
        @(posedge clk);
        #1 d_valid[i] = 1'b0;
    endtask

    // Issue a request with an expected response; check per-cycle ready/valid
    // timing from the accept edge.
    task automatic issue(input int i, input logic we, input logic [2:0] f3,
                         input logic [7:0] addr, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee);
        exp_t e;
        int   w;
        e.rdata = er;
        e.err   = ee;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        drive_req(i, we, f3, addr, wd);
        w = waits(i);
        for (int k = 1; k <= w + 2; k++) begin
            @(negedge clk);
            check($sformatf("inst%0d ready @+%0d a=%02h", i, k, addr), 32'(m_ready[i]), 32'(k == w + 2));
            check($sformatf("inst%0d valid @+%0d a=%02h", i, k, addr), 32'(m_rvalid[i]), 32'(k == w + 1));
        end
    endtask

    // Scoreboard monitor: pops and compares whenever a response appears.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst[i] && m_rvalid[i]) begin
                    exp_t e;
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        check($sformatf("inst%0d unexpected resp", i), 32'(m_rvalid[i]), 32'd0);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("inst%0d resp_rdata", i), m_rdata[i], e.rdata);
                        check($sformatf("inst%0d resp_err", i), 32'(m_err[i]), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        bit saw;
        rst = 2'b11;
        d_valid = '0; d_we = '0; d_f3 = '0; d_addr = '0; d_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst ready", 32'(m_ready), 32'd0);
        check("rst valid", 32'(m_rvalid), 32'd0);
        check("rst rdata0", m_rdata[0], 32'd0);
        check("rst err", 32'(m_err), 32'd0);
        rst = 2'b00;
        #1;
        check("ready after rst", 32'(m_ready), 32'd3);

        // Test 1: SW/LW, no wait states
        issue(0, 1'b1, F3_W,  8'h08, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(0, 1'b0, F3_W,  8'h08, 32'h0, 32'hDEADBEEF, 1'b0);
        // Test 2: byte store, byte loads
        issue(0, 1'b1, F3_B,  8'h09, 32'h00000055, 32'h0, 1'b0);
        issue(0, 1'b0, F3_BU, 8'h09, 32'h0, 32'h00000055, 1'b0);
        issue(0, 1'b0, F3_B,  8'h0B, 32'h0, 32'hFFFFFFDE, 1'b0);
        issue(0, 1'b0, F3_W,  8'h08, 32'h0, 32'hDEAD55EF, 1'b0);
        // Test 3: halfword store/loads (word 0x08 becomes 0x800155EF)
        issue(0, 1'b1, F3_H,  8'h0A, 32'h00008001, 32'h0, 1'b0);
        issue(0, 1'b0, F3_H,  8'h0A, 32'h0, 32'hFFFF8001, 1'b0);
        issue(0, 1'b0, F3_HU, 8'h0A, 32'h0, 32'h00008001, 1'b0);
        // Test 5: misalignment and illegal funct3
        issue(0, 1'b1, F3_W,  8'h04, 32'h11223344, 32'h0, 1'b0);
        issue(0, 1'b0, F3_W,  8'h06, 32'h0, c_MCHK ? 32'h0 : 32'h11223344, c_MCHK);
        issue(0, 1'b0, 3'b011, 8'h04, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b1, 3'b100, 8'h04, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(0, 1'b1, 3'b011, 8'h04, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(0, 1'b0, F3_W,  8'h04, 32'h0, 32'h11223344, 1'b0);
        issue(0, 1'b0, F3_H,  8'h09, 32'h0, c_MCHK ? 32'h0 : 32'h000055EF, c_MCHK);
        issue(0, 1'b1, F3_H,  8'h05, 32'h0000AAAA, 32'h0, c_MCHK);
        issue(0, 1'b0, F3_W,  8'h04, 32'h0, c_MCHK ? 32'h11223344 : 32'h1122AAAA, 1'b0);

        // Test 4: three wait states
        issue(1, 1'b1, F3_W,  8'h10, 32'hCAFEF00D, 32'h0, 1'b0);
        issue(1, 1'b0, F3_W,  8'h10, 32'h0, 32'hCAFEF00D, 1'b0);
        issue(1, 1'b0, F3_BU, 8'h13, 32'h0, 32'h000000CA, 1'b0);

        // Test 6: reset while in WAIT drops the store
        drive_req(1, 1'b1, F3_W, 8'h10, 32'h00001234);
        @(negedge clk);
        check("inst1 ready in WAIT", 32'(m_ready[1]), 32'd0);
        rst[1] = 1'b1;
        #1;
        check("rst6 ready", 32'(m_ready[1]), 32'd0);
        check("rst6 valid", 32'(m_rvalid[1]), 32'd0);
        check("rst6 rdata", m_rdata[1], 32'd0);
        check("rst6 err", 32'(m_err[1]), 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        check("inst1 ready after rst6", 32'(m_ready[1]), 32'd1);
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (m_rvalid[1]) saw = 1'b1;
        end
        check("inst1 no resp after rst6", 32'(saw), 32'd0);
        issue(1, 1'b0, F3_W, 8'h10, 32'h0, 32'hCAFEF00D, 1'b0);

        repeat (3) @(negedge clk);
        check("q0 drained", 32'(q0.size()), 32'd0);
        check("q1 drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
